// File: rtl/pe_array_mv_if.sv
// pe_array_mv_if: start/done handshake and single BRAM port of the matrix-vector engine.
interface pe_array_mv_if;
    logic        start;
    logic        done;
    logic [31:0] BRAM_ADDR;
    logic [7:0]  BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        BRAM_CLK;
    logic [7:0]  BRAM_RDDATA;
    modport master (
        input  start, BRAM_RDDATA,
        output done, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
    );
    modport slave (
        output start, BRAM_RDDATA,
        input  done, BRAM_ADDR, BRAM_WRDATA, BRAM_WE, BRAM_CLK
    );
endinterface

// File: rtl/pe_array_mv.sv
// pe_array_mv: y = M*x over one BRAM port, N parallel 8-bit MAC PEs, results written over x.
module pe_array_mv #(
    parameter int H_SIZE   = 3,
    parameter int PE_DELAY = 16
) (
    input  logic          S_AXI_ACLK,
    input  logic          S_AXI_ARESETN,
    pe_array_mv_if.master bus
);
    localparam int N  = 2 ** H_SIZE;
    localparam int NW = N * (N + 1);
    localparam int CW = $clog2(NW + N + PE_DELAY + 2);
    typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, DONE} state_t;
    state_t                   state_q;
    logic [CW-1:0]            cnt_q, addr_q;
    logic [7:0]               wrdata_q;
    logic                     we_q, done_q;
    logic [N-1:0][7:0]        x_q, acc_q;
    logic [N-1:0][N-1:0][7:0] m_q;
    logic [H_SIZE-1:0]        j, xi;
    logic [2*H_SIZE-1:0]      mi;
    // read data lags the issued address by two cycles, hence the offsets
    assign j  = cnt_q[H_SIZE-1:0];
    assign xi = H_SIZE'(cnt_q - CW'(1));
    assign mi = (2*H_SIZE)'(cnt_q - CW'(N + 1));
    assign bus.BRAM_ADDR   = 32'({addr_q, 2'b00});
    assign bus.BRAM_WRDATA = wrdata_q;
    assign bus.BRAM_WE     = {4{we_q}};
    assign bus.BRAM_CLK    = ~S_AXI_ACLK;
    assign bus.done        = done_q;
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
        if (S_AXI_ARESETN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            x_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                    addr_q  <= '0;
                end
                LOAD: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q < CW'(NW - 1)) addr_q <= cnt_q + CW'(1);
                    if (cnt_q != '0 && cnt_q <= CW'(N)) x_q[xi] <= bus.BRAM_RDDATA;
                    else if (cnt_q > CW'(N) && cnt_q <= CW'(NW)) m_q[mi[2*H_SIZE-1:H_SIZE]][mi[H_SIZE-1:0]] <= bus.BRAM_RDDATA;
                    if (cnt_q == CW'(NW + 1)) begin
                        state_q <= CALC;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        acc_q   <= '0;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q < CW'(N))
                        for (int i = 0; i < N; i++) acc_q[i] <= acc_q[i] + m_q[i][j] * x_q[j];
                    // the remaining cycles model the PE pipeline drain
                    if (cnt_q == CW'(N + PE_DELAY - 1)) begin
                        state_q  <= WRITE;
                        cnt_q    <= '0;
                        addr_q   <= '0;
                        wrdata_q <= acc_q[0];
                        we_q     <= 1'b1;
                    end
                end
                WRITE: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q  <= DONE;
                        addr_q   <= '0;
                        wrdata_q <= '0;
                        we_q     <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        addr_q   <= cnt_q + CW'(1);
                        wrdata_q <= acc_q[j + H_SIZE'(1)];
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_array_mv.sv
// tb_pe_array_mv: directed tests of pe_array_mv against a 2-cycle-latency BRAM model.
module tb_pe_array_mv;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0, pass_n = 0, tot_n = 0, wr_n = 0, done_n = 0;
    logic [7:0] mem [128];
    logic [31:0] wa [256];
    logic [7:0] wd [256];
    logic [3:0] wwe [256];
    int         wc [256];
    pe_array_mv_if bus ();
    pe_array_mv dut (.S_AXI_ACLK(clk), .S_AXI_ARESETN(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        bus.BRAM_RDDATA <= mem[bus.BRAM_ADDR[8:2]];
    end
    always @(negedge clk) begin
        if (bus.BRAM_WE !== 4'h0) begin
            if (wr_n < 256) begin
                wa[wr_n]  <= bus.BRAM_ADDR;
                wd[wr_n]  <= bus.BRAM_WRDATA;
                wwe[wr_n] <= bus.BRAM_WE;
                wc[wr_n]  <= cyc;
            end
            wr_n <= wr_n + 1;
        end
        if (bus.done === 1'b1) done_n <= done_n + 1;
    end
    task automatic fill(input int p);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                mem[j] = (p == 0 || p == 4) ? 8'(j + 1) : p == 1 ? 8'h01 : p == 2 ? 8'h10 : 8'h03;
                mem[8 * (i + 1) + j] = p == 0 ? 8'(i == j) : p == 1 ? 8'(i) : p == 2 ? 8'h10 : p == 3 ? 8'h0B : 8'(i + 1);
            end
    endtask
    task automatic start_op(output int t0);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.start = 1'b0;
    endtask
    task automatic wait_done(output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tot_n++; if (bus.BRAM_ADDR !== 32'h0) $display("FAIL reset addr: got %h want 0", bus.BRAM_ADDR); else pass_n++;
        tot_n++; if (bus.BRAM_WRDATA !== 8'h0) $display("FAIL reset wrdata: got %h want 0", bus.BRAM_WRDATA); else pass_n++;
        tot_n++; if (bus.BRAM_WE !== 4'h0) $display("FAIL reset we: got %h want 0", bus.BRAM_WE); else pass_n++;
        tot_n++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done); else pass_n++;
        tot_n++; if (bus.BRAM_CLK !== 1'b0) $display("FAIL bram_clk high phase: got %b want 0", bus.BRAM_CLK); else pass_n++;
        @(negedge clk);
        #1;
        tot_n++; if (bus.BRAM_CLK !== 1'b1) $display("FAIL bram_clk low phase: got %b want 1", bus.BRAM_CLK); else pass_n++;
        rst = 1'b0;
    endtask
    task automatic test_patterns();
        logic [7:0] ye [4][8];
        int t0, t, bw, bd;
        ye = '{'{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
               '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38},
               '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
               '{8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08}};
        for (int p = 0; p < 4; p++) begin
            fill(p);
            start_op(t0);
            bw = wr_n;
            bd = done_n;
            wait_done(t);
            tot_n++; if (t - t0 !== 106) $display("FAIL p%0d latency: got %0d want 106", p, t - t0); else pass_n++;
            repeat (3) @(negedge clk);
            #1;
            tot_n++; if (wr_n - bw !== 8) $display("FAIL p%0d write count: got %0d want 8", p, wr_n - bw); else pass_n++;
            for (int i = 0; i < 8; i++) begin
                tot_n++;
                if (wa[bw + i] !== 32'(4 * i) || wd[bw + i] !== ye[p][i] || wwe[bw + i] !== 4'hF || wc[bw + i] !== t0 + 98 + i)
                    $display("FAIL p%0d write%0d: addr %h data %h we %h cyc %0d want %h %h f %0d",
                             p, i, wa[bw + i], wd[bw + i], wwe[bw + i], wc[bw + i] - t0, 4 * i, ye[p][i], 98 + i);
                else pass_n++;
            end
            tot_n++; if (done_n - bd !== 1) $display("FAIL p%0d done pulses: got %0d want 1", p, done_n - bd); else pass_n++;
        end
    endtask
    task automatic test_addr_seq();
        int t0, t, bw, bad;
        fill(0);
        start_op(t0);
        bw = wr_n;
        bad = 0;
        for (int k = 0; k < 72; k++) begin
            if (bus.BRAM_ADDR !== 32'(4 * k) || bus.BRAM_WE !== 4'h0) bad++;
            @(posedge clk);
            #1;
        end
        tot_n++; if (bad !== 0) $display("FAIL load addr seq: got %0d bad steps want 0", bad); else pass_n++;
        repeat (25) @(posedge clk);
        #1;
        tot_n++; if (wr_n - bw !== 0) $display("FAIL writes in load/calc: got %0d want 0", wr_n - bw); else pass_n++;
        wait_done(t);
        tot_n++; if (t - t0 !== 106) $display("FAIL addr-run latency: got %0d want 106", t - t0); else pass_n++;
        repeat (3) @(negedge clk);
    endtask
    task automatic test_mid_reset();
        logic [7:0] ye [8];
        int t0, t, bw, bd;
        ye = '{8'h24, 8'h48, 8'h6C, 8'h90, 8'hB4, 8'hD8, 8'hFC, 8'h20};
        fill(4);
        start_op(t0);
        bw = wr_n;
        bd = done_n;
        repeat (85) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tot_n++; if (bus.BRAM_WE !== 4'h0) $display("FAIL midrst we: got %h want 0", bus.BRAM_WE); else pass_n++;
        tot_n++; if (bus.BRAM_ADDR !== 32'h0) $display("FAIL midrst addr: got %h want 0", bus.BRAM_ADDR); else pass_n++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (130) @(negedge clk);
        #1;
        tot_n++; if (wr_n - bw !== 0) $display("FAIL midrst writes: got %0d want 0", wr_n - bw); else pass_n++;
        tot_n++; if (done_n - bd !== 0) $display("FAIL midrst done: got %0d want 0", done_n - bd); else pass_n++;
        start_op(t0);
        bw = wr_n;
        wait_done(t);
        tot_n++; if (t - t0 !== 106) $display("FAIL restart latency: got %0d want 106", t - t0); else pass_n++;
        repeat (3) @(negedge clk);
        #1;
        tot_n++; if (wr_n - bw !== 8) $display("FAIL restart write count: got %0d want 8", wr_n - bw); else pass_n++;
        for (int i = 0; i < 8; i++) begin
            tot_n++;
            if (wa[bw + i] !== 32'(4 * i) || wd[bw + i] !== ye[i])
                $display("FAIL restart write%0d: addr %h data %h want %h %h", i, wa[bw + i], wd[bw + i], 4 * i, ye[i]);
            else pass_n++;
        end
    endtask
    task automatic test_busy_start();
        int t0, t, bw, bd;
        fill(1);
        start_op(t0);
        bw = wr_n;
        bd = done_n;
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (70) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(t);
        tot_n++; if (t - t0 !== 106) $display("FAIL busy latency: got %0d want 106", t - t0); else pass_n++;
        repeat (3) @(negedge clk);
        #1;
        tot_n++; if (done_n - bd !== 1) $display("FAIL busy done pulses: got %0d want 1", done_n - bd); else pass_n++;
        tot_n++; if (wr_n - bw !== 8) $display("FAIL busy write count: got %0d want 8", wr_n - bw); else pass_n++;
        for (int i = 0; i < 8; i++) begin
            tot_n++;
            if (wa[bw + i] !== 32'(4 * i) || wd[bw + i] !== 8'(8 * i))
                $display("FAIL busy write%0d: addr %h data %h want %h %h", i, wa[bw + i], wd[bw + i], 4 * i, 8 * i);
            else pass_n++;
        end
    endtask
    task automatic test_start_held();
        int t1, t2, bd;
        fill(3);
        @(negedge clk);
        bd = done_n;
        bus.start = 1'b1;
        wait_done(t1);
        wait_done(t2);
        bus.start = 1'b0;
        tot_n++; if (t2 - t1 !== 108) $display("FAIL held restart spacing: got %0d want 108", t2 - t1); else pass_n++;
        repeat (4) @(negedge clk);
        #1;
        tot_n++; if (done_n - bd !== 2) $display("FAIL held done pulses: got %0d want 2", done_n - bd); else pass_n++;
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.start = 1'b0;
        test_reset();
        test_patterns();
        test_addr_seq();
        test_mid_reset();
        test_busy_start();
        test_start_held();
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/pe_array_mv.md
Name: pe_array_mv

Overview:
- Matrix-vector multiply engine with a row of N = 2**H_SIZE processing elements (PEs), driven by a single BRAM port.
- On start, it reads an N-element vector and an NxN matrix from BRAM and computes y = M·x with all N PEs in parallel.
- It writes the N results back to BRAM and then pulses done.
- It sits behind an AXI-clocked BRAM controller port, with BRAM clocked on the inverted system clock.

Parameters:
- H_SIZE, 3: log2 of the vector length and of the PE count; N = 2**H_SIZE.
- PE_DELAY, 16: pipeline latency of the PE MAC in cycles; the controller waits this long after the last operand before results are valid.

Ports:
- S_AXI_ACLK  in  1  system clock; all logic on its rising edge.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-high.
- start  in  1  begin one operation; sampled only in IDLE.
- done  out  1  one-cycle pulse when results are written.
- BRAM_ADDR  out  32  byte address, always word-aligned (word index × 4).
- BRAM_WRDATA  out  8  write data.
- BRAM_WE  out  4  byte write enables: 4'hF on a write cycle, else 4'h0.
- BRAM_CLK  out  1  equals ~S_AXI_ACLK, combinational.
- BRAM_RDDATA  in  8  read data.

Behaviour:
- Reset (asynchronous, active-high on S_AXI_ARESETN):
  - state = IDLE.
  - done = 0, BRAM_ADDR = 0, BRAM_WRDATA = 0, BRAM_WE = 0.
  - All vector, matrix and accumulator registers cleared.
  - Reset asserted mid-operation aborts immediately; no further writes occur.
- Memory map (word index w, BRAM_ADDR = 4w):
  - Vector x[j] at w = j, for j = 0..N-1.
  - Matrix M[i][j] at w = N·(i+1) + j.
  - Result y[i] written to w = i, overwriting x.
- Read timing:
  - Registered BRAM_ADDR updates at edge k; BRAM returns data registered at edge k+1; controller samples BRAM_RDDATA at edge k+2.
  - Read latency is therefore 2 cycles; addresses are issued back-to-back, one per cycle.
- IDLE: outputs idle. start = 1 moves to LOAD on the next edge.
- LOAD:
  - Issue word addresses 0 .. N·(N+1)-1 consecutively.
  - Capture returned data into the x buffer (first N words), then M[i][j] row-major.
  - Lasts N·(N+1)+2 cycles, including drain of the read latency.
- CALC:
  - PE i clears its accumulator, then for j = 0..N-1 (one per cycle) does acc_i += M[i][j]·x[j].
  - Then wait PE_DELAY cycles.
  - Lasts N + PE_DELAY cycles.
- Arithmetic:
  - Operands are unsigned 8-bit.
  - Each product and the accumulator are truncated modulo 2**8.
  - y[i] = low 8 bits of the full sum.
- WRITE:
  - One cycle per i = 0..N-1: BRAM_ADDR = 4i, BRAM_WRDATA = y[i], BRAM_WE = 4'hF.
  - Lasts N cycles; BRAM_WE = 0 in every other state.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Total from start-sampling edge to done high, for defaults: 72+2 + 8+16 + 8 = 106 cycles, then done.
- start asserted outside IDLE is ignored.
- start held high through DONE begins a new operation on return to IDLE.

Test Plan:
- Reset with S_AXI_ARESETN = 1:
  - All outputs 0.
  - BRAM_CLK = ~S_AXI_ACLK throughout.
- x = 1,2,..,8, M = identity, start pulse:
  - Writes y = 01..08 to byte addresses 0x00..0x1C.
  - BRAM_WE = F only in those 8 cycles.
  - done pulses once, 106 cycles after start.
- x all 0x01, M[i][j] = i:
  - y[i] = 8·i mod 256, i.e. 00,08,10,18,20,28,30,38.
- Overflow: x all 0x10, M all 0x10:
  - Each y = 0x800 mod 256 = 0x00.
  - x all 0x03, M all 0x0B gives y = 0x108 mod 256 = 0x08.
- Address sequence check:
  - BRAM_ADDR steps 0x000, 0x004, .. 0x11C during LOAD.
  - No writes during LOAD or CALC.
- Mid-operation and busy-start cases:
  - Assert reset in the middle of CALC: no writes occur, done stays 0.
  - A second start after reset completes normally.
  - start re-pulsed during LOAD: no effect.
